ln_stat_accum: RTL

//  Streaming per-token statistics engine for the LayerNorm/RMSNorm path. Consumes one token's

---
 rtl/ln_stat_accum_if.sv | 43 ++++
 rtl/ln_stat_accum.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ln_stat_accum_if.sv
// Bundle of configuration, input-beat, output-statistics and status signals for ln_stat_accum.
//   master : the side that configures the engine, sends beats and accepts results
//   slave  : the statistics engine
// Signals:
//   cfg_start/cfg_rms_mode/cfg_ch_num/cfg_tokens : batch configuration, latched on cfg_start in idle
//   in_valid/in_ready/in_data                    : one Tout-wide channel group per beat
//   out_valid/out_ready/out_sum/out_sumsq/out_tok: per-token statistics
//   busy/done                                    : batch status
interface ln_stat_accum_if #(
  parameter int unsigned TOUT    = 32,
  parameter int unsigned DAT_DW  = 16,
  parameter int unsigned GRP_MAX = 256,
  parameter int unsigned TOK_W   = 16
);
  localparam int unsigned CH_W  = $clog2(TOUT * GRP_MAX) + 1;
  localparam int unsigned SUM_W = DAT_DW + $clog2(TOUT * GRP_MAX);
  localparam int unsigned SQ_W  = 2 * DAT_DW + $clog2(TOUT * GRP_MAX);

  logic                     cfg_start;
  logic                     cfg_rms_mode;
  logic [CH_W-1:0]          cfg_ch_num;
  logic [TOK_W-1:0]         cfg_tokens;
  logic                     in_valid;
  logic                     in_ready;
  logic [TOUT*DAT_DW-1:0]   in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [SUM_W-1:0]         out_sum;
  logic [SQ_W-1:0]          out_sumsq;
  logic [TOK_W-1:0]         out_tok;
  logic                     busy;
  logic                     done;

  modport master (
    output cfg_start, cfg_rms_mode, cfg_ch_num, cfg_tokens, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_sumsq, out_tok, busy, done
  );

  modport slave (
    input  cfg_start, cfg_rms_mode, cfg_ch_num, cfg_tokens, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_sumsq, out_tok, busy, done
  );
endinterface

// File: rtl/ln_stat_accum.sv
// Streaming per-token statistics engine for the LayerNorm/RMSNorm path.
// Each token arrives as ceil(ch_num/TOUT) beats of TOUT signed samples; the engine emits the exact
// integer sum (forced to 0 in RMS mode) and sum of squares of the real channels of every token.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : ln_stat_accum_if.slave (configuration, input beats, output statistics, busy/done)
// Pipeline: S1 registers the masked lane-tree sum/sum-of-squares of one beat, S2 accumulates and
// loads the output register on the last beat of a token (output visible two cycles after the
// last beat is accepted).
module ln_stat_accum #(
  parameter int unsigned TOUT    = 32,
  parameter int unsigned DAT_DW  = 16,
  parameter int unsigned GRP_MAX = 256,
  parameter int unsigned TOK_W   = 16
) (
  input logic            clk,
  input logic            rst,
  ln_stat_accum_if.slave bus
);

  localparam int unsigned CH_W  = $clog2(TOUT * GRP_MAX) + 1;
  localparam int unsigned SUM_W = DAT_DW + $clog2(TOUT * GRP_MAX);
  localparam int unsigned SQ_W  = 2 * DAT_DW + $clog2(TOUT * GRP_MAX);
  localparam int unsigned GRP_W = $clog2(GRP_MAX) + 1;

  typedef enum logic [1:0] {StIdle, StAccum, StFin} state_e;

  state_e                  state_q, state_d;
  logic                    rms_q, rms_d;
  logic [CH_W-1:0]         ch_num_q, ch_num_d;
  logic [TOK_W-1:0]        tokens_q, tokens_d;
  logic [GRP_W-1:0]        grp_num_q, grp_num_d;
  logic [GRP_W-1:0]        grp_cnt_q, grp_cnt_d;
  logic [TOK_W-1:0]        tokens_in_q, tokens_in_d;

  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_last_q, s1_last_d;
  logic signed [SUM_W-1:0] s1_sum_q, s1_sum_d;
  logic [SQ_W-1:0]         s1_sq_q, s1_sq_d;

  logic signed [SUM_W-1:0] acc_sum_q, acc_sum_d;
  logic [SQ_W-1:0]         acc_sq_q, acc_sq_d;

  logic                    out_valid_q, out_valid_d;
  logic signed [SUM_W-1:0] out_sum_q, out_sum_d;
  logic [SQ_W-1:0]         out_sumsq_q, out_sumsq_d;
  logic [TOK_W-1:0]        out_tok_q, out_tok_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    in_ready;
  logic                    beat_fire;
  logic                    beat_last;
  logic                    out_hs;

  // Lane tree over one beat
  logic signed [SUM_W-1:0]    lane_sum;
  logic [SQ_W-1:0]            lane_sq;
  logic [31:0]                grp_base;
  logic signed [DAT_DW-1:0]   sample;
  logic signed [2*DAT_DW-1:0] sample_x;
  logic signed [2*DAT_DW-1:0] prod;

  // A result waiting in the output register, or a last beat still in S1, blocks new beats so the
  // output register can never be overwritten before it is consumed.
  assign in_ready  = (state_q == StAccum) && !s1_last_q && !out_valid_q &&
                     (tokens_in_q < tokens_q);
  assign beat_fire = bus.in_valid && in_ready;
  assign beat_last = (grp_cnt_q == grp_num_q - GRP_W'(1));
  assign out_hs    = out_valid_q && bus.out_ready;

  always_comb begin
    lane_sum = '0;
    lane_sq  = '0;
    sample   = '0;
    sample_x = '0;
    prod     = '0;
    grp_base = 32'(grp_cnt_q) * TOUT;
    for (int unsigned i = 0; i < TOUT; i++) begin
      sample = bus.in_data[i*DAT_DW +: DAT_DW];
      // Padding lanes beyond the real channel count contribute nothing.
      if (grp_base + i >= 32'(ch_num_q)) begin
        sample = '0;
      end
      sample_x = (2*DAT_DW)'(sample);
      prod     = sample_x * sample_x;
      lane_sum = lane_sum + SUM_W'(sample);
      lane_sq  = lane_sq + SQ_W'(unsigned'(prod));
    end
  end

  always_comb begin
    state_d     = state_q;
    rms_d       = rms_q;
    ch_num_d    = ch_num_q;
    tokens_d    = tokens_q;
    grp_num_d   = grp_num_q;
    grp_cnt_d   = grp_cnt_q;
    tokens_in_d = tokens_in_q;
    s1_valid_d  = beat_fire;
    s1_last_d   = beat_fire && beat_last;
    s1_sum_d    = s1_sum_q;
    s1_sq_d     = s1_sq_q;
    acc_sum_d   = acc_sum_q;
    acc_sq_d    = acc_sq_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_sumsq_d = out_sumsq_q;
    out_tok_d   = out_tok_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    // S1: capture the beat's tree results
    if (beat_fire) begin
      s1_sum_d = rms_q ? '0 : lane_sum;
      s1_sq_d  = lane_sq;
      if (beat_last) begin
        grp_cnt_d   = '0;
        tokens_in_d = tokens_in_q + TOK_W'(1);
      end else begin
        grp_cnt_d = grp_cnt_q + GRP_W'(1);
      end
    end

    // Output handshake frees the output register
    if (out_hs) begin
      out_valid_d = 1'b0;
      out_tok_d   = out_tok_q + TOK_W'(1);
    end

    // S2: accumulate, or finish the token and restart the accumulators from zero
    if (s1_valid_q) begin
      if (s1_last_q) begin
        out_sum_d   = acc_sum_q + s1_sum_q;
        out_sumsq_d = acc_sq_q + s1_sq_q;
        out_valid_d = 1'b1;
        acc_sum_d   = '0;
        acc_sq_d    = '0;
      end else begin
        acc_sum_d = acc_sum_q + s1_sum_q;
        acc_sq_d  = acc_sq_q + s1_sq_q;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (bus.cfg_start) begin
          rms_d       = bus.cfg_rms_mode;
          ch_num_d    = bus.cfg_ch_num;
          tokens_d    = bus.cfg_tokens;
          grp_num_d   = GRP_W'((32'(bus.cfg_ch_num) + TOUT - 1) / TOUT);
          grp_cnt_d   = '0;
          tokens_in_d = '0;
          out_tok_d   = '0;
          acc_sum_d   = '0;
          acc_sq_d    = '0;
          busy_d      = 1'b1;
          if ((bus.cfg_tokens == '0) || (bus.cfg_ch_num == '0)) begin
            state_d = StFin;
            done_d  = 1'b1;
          end else begin
            state_d = StAccum;
          end
        end
      end
      StAccum: begin
        if (out_hs && (out_tok_q == tokens_q - TOK_W'(1))) begin
          state_d = StFin;
          done_d  = 1'b1;
        end
      end
      StFin: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rms_q       <= 1'b0;
      ch_num_q    <= '0;
      tokens_q    <= '0;
      grp_num_q   <= '0;
      grp_cnt_q   <= '0;
      tokens_in_q <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_sum_q    <= '0;
      s1_sq_q     <= '0;
      acc_sum_q   <= '0;
      acc_sq_q    <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_sumsq_q <= '0;
      out_tok_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rms_q       <= rms_d;
      ch_num_q    <= ch_num_d;
      tokens_q    <= tokens_d;
      grp_num_q   <= grp_num_d;
      grp_cnt_q   <= grp_cnt_d;
      tokens_in_q <= tokens_in_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_sum_q    <= s1_sum_d;
      s1_sq_q     <= s1_sq_d;
      acc_sum_q   <= acc_sum_d;
      acc_sq_q    <= acc_sq_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_sumsq_q <= out_sumsq_d;
      out_tok_q   <= out_tok_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_sumsq = out_sumsq_q;
  assign bus.out_tok   = out_tok_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
